// File: rtl/e15_arb_pkg.sv
// Shared types and constants for the E15 two-core ALU arbiter.
package e15_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arbState_t;

  localparam int   W_DEF = 4;
  localparam logic REQ0  = 1'b0;
  localparam logic REQ1  = 1'b1;

endpackage

// File: rtl/e15_rr_pick.sv
// Two-way combinational round-robin picker: a lone requester wins, a tie goes
// to the requester that was not granted last.
module e15_rr_pick
  import e15_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  // Grant selection
  always_comb begin
    gnt_valid = valid0 | valid1;
    gnt_id    = REQ0;
    if (valid0 && valid1) begin
      gnt_id = ~last;
    end else if (valid1) begin
      gnt_id = REQ1;
    end else begin
      gnt_id = REQ0;
    end
  end

endmodule

// File: rtl/e15_alu_arbiter.sv
// Time-shares one external add/sub ALU between two E15 cores.
// Optional per-requester saturating grant counters: define E15_ARB_GRANT_CNT_EN.
module e15_alu_arbiter
  import e15_arb_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_add_not_sub,
  input  logic [W-1:0] req0_src,
  input  logic [W-1:0] req0_dst,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_res,
  output logic         rsp0_z,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_add_not_sub,
  input  logic [W-1:0] req1_src,
  input  logic [W-1:0] req1_dst,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_res,
  output logic         rsp1_z,
  output logic         alu_add_not_sub,
  output logic [W-1:0] alu_src,
  output logic [W-1:0] alu_dst,
  input  logic [W-1:0] alu_res,
  input  logic         alu_z,
  output logic         busy
`ifdef E15_ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  arbState_t      state;
  arbState_t      stateNext;
  logic           lastGrant;
  logic           gntId;
  logic           pickValid;
  logic           pickId;
  logic           grantFire;
  logic           rspReadySel;
  logic           opAdd;
  logic [W-1:0]   opSrc;
  logic [W-1:0]   opDst;
  logic [W-1:0]   resQ;
  logic           zQ;

  e15_rr_pick uPick (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last      (lastGrant),
    .gnt_valid (pickValid),
    .gnt_id    (pickId)
  );

  // Ready is held low while reset is asserted so no core sees a phantom accept.
  assign grantFire   = (state == IDLE) && pickValid && !rst;
  assign req0_ready  = grantFire && (pickId == REQ0);
  assign req1_ready  = grantFire && (pickId == REQ1);
  assign rspReadySel = (gntId == REQ1) ? rsp1_ready : rsp0_ready;

  assign rsp0_valid  = (state == RESP) && (gntId == REQ0);
  assign rsp1_valid  = (state == RESP) && (gntId == REQ1);
  assign rsp0_res    = resQ;
  assign rsp1_res    = resQ;
  assign rsp0_z      = zQ;
  assign rsp1_z      = zQ;
  assign busy        = (state != IDLE);

  // The op registers only change on a grant, so they hold the last op outside EXEC.
  assign alu_add_not_sub = opAdd;
  assign alu_src         = opSrc;
  assign alu_dst         = opDst;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (pickValid) begin
          stateNext = EXEC;
        end else begin
          stateNext = IDLE;
        end
      end
      EXEC: stateNext = RESP;
      RESP: begin
        if (rspReadySel) begin
          stateNext = IDLE;
        end else begin
          stateNext = RESP;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand latch on grant, result capture in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= REQ1;
      gntId     <= REQ0;
      opAdd     <= 1'b0;
      opSrc     <= '0;
      opDst     <= '0;
      resQ      <= '0;
      zQ        <= 1'b0;
    end else begin
      if (grantFire) begin
        gntId     <= pickId;
        lastGrant <= pickId;
        if (pickId == REQ1) begin
          opAdd <= req1_add_not_sub;
          opSrc <= req1_src;
          opDst <= req1_dst;
        end else begin
          opAdd <= req0_add_not_sub;
          opSrc <= req0_src;
          opDst <= req0_dst;
        end
      end
      if (state == EXEC) begin
        resQ <= alu_res;
        zQ   <= alu_z;
      end
    end
  end

  if (CNT_W < 1) begin : gBadCntW
  end

`ifdef E15_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt0Q;
  logic [CNT_W-1:0] cnt1Q;

  // Saturating grant counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0Q <= '0;
      cnt1Q <= '0;
    end else begin
      if (grantFire && (pickId == REQ0) && (cnt0Q != '1)) begin
        cnt0Q <= cnt0Q + CNT_W'(1);
      end
      if (grantFire && (pickId == REQ1) && (cnt1Q != '1)) begin
        cnt1Q <= cnt1Q + CNT_W'(1);
      end
    end
  end

  assign gnt_cnt0 = cnt0Q;
  assign gnt_cnt1 = cnt1Q;
`endif

endmodule

// File: tb/tb_e15_alu_arbiter.sv
// Self-checking bench for e15_alu_arbiter: directed steps plus randomized
// traffic against a transaction-level round-robin / modular-arithmetic model.
module tb_e15_alu_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready, req0_add_not_sub;
  logic [W-1:0] req0_src, req0_dst;
  logic         rsp0_valid, rsp0_ready, rsp0_z;
  logic [W-1:0] rsp0_res;
  logic         req1_valid, req1_ready, req1_add_not_sub;
  logic [W-1:0] req1_src, req1_dst;
  logic         rsp1_valid, rsp1_ready, rsp1_z;
  logic [W-1:0] rsp1_res;
  logic         alu_add_not_sub, alu_z;
  logic [W-1:0] alu_src, alu_dst, alu_res;
  logic         busy;
`ifdef E15_ARB_GRANT_CNT_EN
  logic [7:0]   gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int lastG  = 1;
  int cnt0   = 0;
  int cnt1   = 0;

  e15_alu_arbiter #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_add_not_sub(req0_add_not_sub),
    .req0_src(req0_src), .req0_dst(req0_dst),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_z(rsp0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_add_not_sub(req1_add_not_sub),
    .req1_src(req1_src), .req1_dst(req1_dst),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_z(rsp1_z),
    .alu_add_not_sub(alu_add_not_sub), .alu_src(alu_src), .alu_dst(alu_dst),
    .alu_res(alu_res), .alu_z(alu_z), .busy(busy)
`ifdef E15_ARB_GRANT_CNT_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // External ALU
  assign alu_res = alu_add_not_sub ? (alu_dst + alu_src) : (alu_dst - alu_src);
  assign alu_z   = (alu_res == 4'h0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] calc(input logic add, input logic [3:0] s, input logic [3:0] d);
    int r;
    if (add) r = int'(d) + int'(s);
    else     r = int'(d) - int'(s) + 16;
    return 4'(r % 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int id, input logic v, input logic add,
                        input logic [3:0] s, input logic [3:0] d);
    if (id == 0) begin
      req0_valid = v; req0_add_not_sub = add; req0_src = s; req0_dst = d;
    end else begin
      req1_valid = v; req1_add_not_sub = add; req1_src = s; req1_dst = d;
    end
  endtask

  task automatic randReq(input int id);
    setReq(id, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
  endtask

  task automatic checkResp(input int w, input logic [3:0] er, input logic ez, input string ph);
    check({ph, "_rsp0_valid"}, {31'd0, rsp0_valid}, {31'd0, (w == 0)});
    check({ph, "_rsp1_valid"}, {31'd0, rsp1_valid}, {31'd0, (w == 1)});
    check({ph, "_rsp0_res"}, {28'd0, rsp0_res}, {28'd0, er});
    check({ph, "_rsp1_res"}, {28'd0, rsp1_res}, {28'd0, er});
    check({ph, "_rsp_z"}, {31'd0, (w == 0) ? rsp0_z : rsp1_z}, {31'd0, ez});
    check({ph, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    check({ph, "_ready1"}, {31'd0, req1_ready}, 32'd0);
    check({ph, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // One full transaction from an IDLE cycle: grant, EXEC, RESP (with hold), consume.
  task automatic runTxn(input int hold, input bit reissue);
    int w;
    logic add;
    logic [3:0] s, d, er;
    logic ez;
    #1;
    if (req0_valid && req1_valid) w = (lastG == 0) ? 1 : 0;
    else if (req0_valid)          w = 0;
    else                          w = 1;
    if (w == 0) begin add = req0_add_not_sub; s = req0_src; d = req0_dst; end
    else        begin add = req1_add_not_sub; s = req1_src; d = req1_dst; end
    er = calc(add, s, d);
    ez = (er == 4'h0);
    check("idle_ready0", {31'd0, req0_ready}, {31'd0, (w == 0)});
    check("idle_ready1", {31'd0, req1_ready}, {31'd0, (w == 1)});
    check("idle_busy", {31'd0, busy}, 32'd0);
    step();
    if (reissue) randReq(w);
    else setReq(w, 1'b0, 1'b0, 4'h0, 4'h0);
    #1;
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("exec_ready0", {31'd0, req0_ready}, 32'd0);
    check("exec_ready1", {31'd0, req1_ready}, 32'd0);
    check("exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("exec_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("exec_alu_op", {31'd0, alu_add_not_sub}, {31'd0, add});
    check("exec_alu_src", {28'd0, alu_src}, {28'd0, s});
    check("exec_alu_dst", {28'd0, alu_dst}, {28'd0, d});
    step();
    checkResp(w, er, ez, "resp");
    for (int i = 0; i < hold; i++) begin
      if (w == 0) rsp1_ready = 1'($urandom_range(0, 1));
      else        rsp0_ready = 1'($urandom_range(0, 1));
      step();
      checkResp(w, er, ez, "hold");
    end
    if (w == 0) rsp0_ready = 1'b1;
    else        rsp1_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    lastG = w;
    if (w == 0 && cnt0 < 255) cnt0++;
    if (w == 1 && cnt1 < 255) cnt1++;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_alu", {23'd0, alu_add_not_sub, alu_src, alu_dst}, 32'd0);
    check("rst_res", {26'd0, rsp0_res, rsp0_z, rsp1_z}, 32'd0);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    lastG = 1;
    cnt0 = 0;
    cnt1 = 0;
  endtask

  initial begin
    rst = 1'b1;
    setReq(0, 1'b0, 1'b0, 4'h0, 4'h0);
    setReq(1, 1'b0, 1'b0, 4'h0, 4'h0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Single requester: 4 + 3
    applyReset();
    setReq(0, 1'b1, 1'b1, 4'd3, 4'd4);
    runTxn(0, 1'b0);

    // Both valid straight out of reset: 5-5 then 2+1, then alternating
    applyReset();
    setReq(0, 1'b1, 1'b0, 4'd5, 4'd5);
    setReq(1, 1'b1, 1'b1, 4'd1, 4'd2);
    runTxn(0, 1'b1);
    runTxn(0, 1'b1);
    runTxn(0, 1'b1);
    runTxn(0, 1'b1);

    // Response back-pressure with req1 waiting, then req1 served next
    runTxn(5, 1'b0);
    runTxn(0, 1'b0);

    // Wrap-around cases
    setReq(0, 1'b1, 1'b0, 4'd1, 4'd0);
    runTxn(0, 1'b0);
    setReq(1, 1'b1, 1'b1, 4'd8, 4'd8);
    runTxn(1, 1'b0);

    // Reset while in EXEC discards the operation
    setReq(0, 1'b1, 1'b1, 4'd2, 4'd2);
    step();
    setReq(0, 1'b0, 1'b0, 4'h0, 4'h0);
    #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    applyReset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    setReq(1, 1'b1, 1'b0, 4'd3, 4'd9);
    runTxn(0, 1'b0);

    // Randomized traffic; waiting requests are kept stable
    for (int n = 0; n < 40; n++) begin
      if (!req0_valid && ($urandom_range(0, 1) == 1)) randReq(0);
      if (!req1_valid && ($urandom_range(0, 1) == 1)) randReq(1);
      if (!req0_valid && !req1_valid) randReq($urandom_range(0, 1));
      runTxn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    setReq(0, 1'b0, 1'b0, 4'h0, 4'h0);
    setReq(1, 1'b0, 1'b0, 4'h0, 4'h0);
    step();

`ifdef E15_ARB_GRANT_CNT_EN
    check("cnt0_mid", {24'd0, gnt_cnt0}, 32'(cnt0));
    check("cnt1_mid", {24'd0, gnt_cnt1}, 32'(cnt1));
    for (int n = 0; n < 300; n++) begin
      randReq(0);
      runTxn(0, 1'b0);
    end
    step();
    check("cnt0_sat", {24'd0, gnt_cnt0}, 32'd255);
    check("cnt1_hold", {24'd0, gnt_cnt1}, 32'(cnt1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
